// File: rtl/sseg_sched_pkg.sv
// Shared types and constants for the seven-segment scan scheduler.
package sseg_sched_pkg;

  typedef enum logic {ST_DEAD = 1'b0, ST_ON = 1'b1} slot_state_t;

  localparam int NUM_DIGITS = 8;
  localparam int DIGIT_W    = 4;

  typedef logic [DIGIT_W-1:0] nibble_t;

  function automatic nibble_t get_nibble(input logic [NUM_DIGITS*DIGIT_W-1:0] word,
                                         input logic [2:0] idx);
    return word[idx*DIGIT_W +: DIGIT_W];
  endfunction

endpackage

// File: rtl/sseg_lz_mask.sv
// Leading-zero mask: digit i is blanked when blanking is enabled and nibbles i..7 are all zero.
module sseg_lz_mask
  import sseg_sched_pkg::*;
(
  input  logic [NUM_DIGITS*DIGIT_W-1:0] shadow,
  input  logic                          blank_lz,
  output logic [NUM_DIGITS-1:0]         lz
);

  // Digit 0 always shows, so its own nibble never influences the mask.
  logic unused_low;
  assign unused_low = ^shadow[DIGIT_W-1:0];

  assign lz[0] = 1'b0;

  for (genvar gi = 1; gi < NUM_DIGITS; gi++) begin : g_lz
    assign lz[gi] = blank_lz && (shadow[NUM_DIGITS*DIGIT_W-1:gi*DIGIT_W] == '0);
  end

endmodule

// File: rtl/sseg_scan_scheduler.sv
// Eight-digit seven-segment scan scheduler: slot timing, dead time, PWM, masking,
// leading-zero blanking and frame-synchronous value loading.
module sseg_scan_scheduler
  import sseg_sched_pkg::*;
#(
  parameter int TICKS_PER_DIGIT = 100_000,
  parameter int DEAD_TICKS      = 1_000,
  parameter int NUM_DIGITS      = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [31:0]             hex_in,
  input  logic                    load,
  input  logic [NUM_DIGITS-1:0]   digit_en,
  input  logic                    blank_lz,
  input  logic [3:0]              brightness,
  output logic [2:0]              anode_index,
  output logic [3:0]              hex_out,
  output logic                    is_led_on,
  output logic                    frame_done
);

  localparam int CNT_W = $clog2(TICKS_PER_DIGIT);
  localparam int IDX_W = $clog2(NUM_DIGITS);
  localparam logic [CNT_W-1:0] LAST_CNT   = CNT_W'(TICKS_PER_DIGIT - 1);
  localparam logic [CNT_W-1:0] DEAD_CNT   = CNT_W'(DEAD_TICKS);
  localparam logic [IDX_W-1:0] LAST_DIGIT = IDX_W'(NUM_DIGITS - 1);

  logic [CNT_W-1:0] slot_cnt_reg, slot_cnt_next;
  logic [IDX_W-1:0] digit_reg, digit_next;
  slot_state_t      state_reg, state_next;
  logic [31:0]      shadow_reg, shadow_next;
  logic [31:0]      pending_reg, pending_next;
  logic             pending_valid_reg, pending_valid_next;
  logic             frame_end;

  logic [NUM_DIGITS-1:0] lz_next;
  logic [3:0]            on_phase;
  nibble_t               hex_next;
  logic                  led_next;
  logic                  frame_done_next;

  logic [2:0] anode_reg;
  nibble_t    hex_reg;
  logic       led_reg;
  logic       frame_done_reg;

  always_comb begin
    frame_end     = (slot_cnt_reg == LAST_CNT) && (digit_reg == LAST_DIGIT);
    slot_cnt_next = slot_cnt_reg + 1'b1;
    digit_next    = digit_reg;
    if (slot_cnt_reg == LAST_CNT) begin
      slot_cnt_next = '0;
      digit_next    = (digit_reg == LAST_DIGIT) ? '0 : digit_reg + 1'b1;
    end
  end

  // A load landing on the boundary cycle bypasses pending and goes straight to shadow.
  always_comb begin
    shadow_next        = shadow_reg;
    pending_next       = pending_reg;
    pending_valid_next = pending_valid_reg;
    if (load) pending_next = hex_in;
    if (frame_end) begin
      pending_valid_next = 1'b0;
      if (load)                   shadow_next = hex_in;
      else if (pending_valid_reg) shadow_next = pending_reg;
    end else if (load) begin
      pending_valid_next = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      slot_cnt_reg      <= '0;
      digit_reg         <= '0;
      shadow_reg        <= '0;
      pending_reg       <= '0;
      pending_valid_reg <= 1'b0;
    end else begin
      slot_cnt_reg      <= slot_cnt_next;
      digit_reg         <= digit_next;
      shadow_reg        <= shadow_next;
      pending_reg       <= pending_next;
      pending_valid_reg <= pending_valid_next;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_reg <= ST_DEAD;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next = (slot_cnt_next < DEAD_CNT) ? ST_DEAD : ST_ON;
  end

  sseg_lz_mask u_lz_mask (
    .shadow   (shadow_next),
    .blank_lz (blank_lz),
    .lz       (lz_next)
  );

  // Outputs are computed from next-cycle state so the flops line up with slot_cnt_reg.
  always_comb begin
    on_phase        = 4'(slot_cnt_next - DEAD_CNT);
    hex_next        = get_nibble(shadow_next, 3'(digit_next));
    led_next        = (state_next == ST_ON) && digit_en[digit_next] && !lz_next[digit_next]
                      && (on_phase <= brightness);
    frame_done_next = (slot_cnt_next == LAST_CNT) && (digit_next == LAST_DIGIT);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      anode_reg      <= '0;
      hex_reg        <= '0;
      led_reg        <= 1'b0;
      frame_done_reg <= 1'b0;
    end else begin
      anode_reg      <= 3'(digit_next);
      hex_reg        <= hex_next;
      led_reg        <= (state_reg == ST_DEAD || state_reg == ST_ON) && led_next;
      frame_done_reg <= frame_done_next;
    end
  end

  assign anode_index = anode_reg;
  assign hex_out     = hex_reg;
  assign is_led_on   = led_reg;
  assign frame_done  = frame_done_reg;

endmodule
